edge_event_arbiter: RTL and testbench

Multi-channel rising-edge event collector and scheduler. Each of `N_CH` asynchronous-to-software level inputs passes through a registered rising-edge pulse stage. Each edge sets a per-channel pending bit. A round-robin arbiter presents one pending event at a time on a single valid/ready event port. It sits between the pulse-generating edge detectors and the downstream event consumer (interrupt controller / logger), so that no edge is lost silently.

---
 rtl/edge_arb_pkg.sv | 6 +
 rtl/edge_event_arbiter_if.sv | 11 +
 rtl/rise_pulse.sv | 23 ++
 rtl/edge_event_arbiter.sv | 120 ++++++++++++
 tb/tb_edge_event_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_arb_pkg.sv
// Shared types and limits for the edge event arbiter.
package edge_arb_pkg;
    typedef enum logic {ST_IDLE, ST_HOLD} out_state_t;

    localparam int MAX_CH = 16;
endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event port: one channel id per valid/ready handshake.
interface edge_event_arbiter_if #(
    parameter int ID_W = 2
);
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;

    modport master (output evt_valid, output evt_id, input evt_ready);
    modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/rise_pulse.sv
// One-channel registered rising-edge detector: one-cycle pulse per low->high.
module rise_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);
    logic prev_reg;
    logic pulse_reg;

    // prev clears on reset, so an input already high at release yields one pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            prev_reg  <= d;
            pulse_reg <= d & ~prev_reg;
        end
    end

    assign pulse = pulse_reg;
endmodule

// File: rtl/edge_event_arbiter.sv
// Collects per-channel rising edges into pending bits and hands them out
// one at a time, round-robin, on a valid/ready event port.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int ID_W = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      sig_in,
    input  logic [N_CH-1:0]      ch_en,
    input  logic [N_CH-1:0]      ovf_clr,
    output logic [N_CH-1:0]      pending,
    output logic [N_CH-1:0]      ovf,
    edge_event_arbiter_if.master evt
);
    if (N_CH < 2 || N_CH > MAX_CH) begin : g_bad_n_ch
        $error("edge_event_arbiter: N_CH out of range");
    end

    // Search starts just after the last grant: rotate, take lowest set bit, un-rotate.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_CH-1:0] req,
                                                 input logic [ID_W-1:0] last);
        logic [2*N_CH-1:0] dbl;
        logic [N_CH-1:0]   rot;
        logic [ID_W-1:0]   pick;
        logic              found;
        int                off;
        int                idx;
        off = int'(last) + 1;
        if (off >= N_CH) off = 0;
        dbl   = {req, req};
        rot   = N_CH'(dbl >> off);
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                idx   = i + off;
                if (idx >= N_CH) idx = idx - N_CH;
                pick  = ID_W'(idx);
            end
        end
        return pick;
    endfunction

    logic [N_CH-1:0] edge_q;
    logic [N_CH-1:0] pending_reg, pending_next;
    logic [N_CH-1:0] ovf_reg, ovf_next;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] granted;
    logic [ID_W-1:0] last_id_reg;
    logic [ID_W-1:0] evt_id_reg;
    logic [ID_W-1:0] grant_id;
    logic            evt_valid_reg;
    logic            load;
    logic            grant_vld;
    out_state_t      state_reg;

    assign req       = pending_reg & ch_en;
    assign load      = (state_reg == ST_IDLE) || evt.evt_ready;
    assign grant_id  = rr_pick(req, last_id_reg);
    assign grant_vld = load && (|req);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        rise_pulse u_rise (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (sig_in[gi]),
            .pulse (edge_q[gi])
        );

        assign granted[gi] = grant_vld && (grant_id == ID_W'(gi));

        // A fresh edge outranks this cycle's grant: the channel re-pends.
        assign pending_next[gi] = !ch_en[gi] ? 1'b0 :
                                  edge_q[gi] ? 1'b1 :
                                  granted[gi] ? 1'b0 : pending_reg[gi];

        assign ovf_next[gi] = (edge_q[gi] & pending_reg[gi] & ch_en[gi] & ~granted[gi])
                            | (ovf_reg[gi] & ~ovf_clr[gi]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
            ovf_reg     <= '0;
        end else begin
            pending_reg <= pending_next;
            ovf_reg     <= ovf_next;
        end
    end

    // HOLD keeps id/valid frozen until the consumer takes the event,
    // even if its channel is disabled meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            evt_valid_reg <= 1'b0;
            evt_id_reg    <= '0;
            last_id_reg   <= ID_W'(N_CH - 1);
        end else if (load) begin
            if (grant_vld) begin
                state_reg     <= ST_HOLD;
                evt_valid_reg <= 1'b1;
                evt_id_reg    <= grant_id;
                last_id_reg   <= grant_id;
            end else begin
                state_reg     <= ST_IDLE;
                evt_valid_reg <= 1'b0;
            end
        end
    end

    assign evt.evt_valid = evt_valid_reg;
    assign evt.evt_id    = evt_id_reg;
    assign pending       = pending_reg;
    assign ovf           = ovf_reg;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: scenario tasks with inline checks plus an
// event scoreboard fed with expected ids and drained by the handshake monitor.
module tb_edge_event_arbiter;
    localparam int N_CH = 4;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] sig_in;
    logic [N_CH-1:0] ch_en;
    logic [N_CH-1:0] ovf_clr;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] ovf;

    int checks = 0;
    int errors = 0;
    logic [ID_W-1:0] exp_q[$];

    edge_event_arbiter_if #(.ID_W(ID_W)) evt_if ();

    edge_event_arbiter #(.N_CH(N_CH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig_in  (sig_in),
        .ch_en   (ch_en),
        .ovf_clr (ovf_clr),
        .pending (pending),
        .ovf     (ovf),
        .evt     (evt_if)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after posedge, so the negedge sees what the next posedge samples.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected: got id=%0d, required no event", evt_if.evt_id);
            end else begin
                logic [ID_W-1:0] want;
                want = exp_q.pop_front();
                if (evt_if.evt_id !== want) begin
                    errors++;
                    $display("FAIL evt_id: got %0d, required %0d", evt_if.evt_id, want);
                end else begin
                    $display("evt id=%0d at %0t", evt_if.evt_id, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        sig_in           = '0;
        ch_en            = 4'hF;
        ovf_clr          = '0;
        evt_if.evt_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        sig_in           = '0;
        ch_en            = '0;
        ovf_clr          = '0;
        evt_if.evt_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (evt_if.evt_valid !== 1'b0 || evt_if.evt_id !== 2'd0 || pending !== 4'h0 || ovf !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b id=%0d pend=%h ovf=%h, required 0 0 0 0",
                     evt_if.evt_valid, evt_if.evt_id, pending, ovf);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (evt_if.evt_valid !== 1'b0 || pending !== 4'h0) begin
            errors++;
            $display("FAIL reset_release: got valid=%b pend=%h, required 0 0", evt_if.evt_valid, pending);
        end
    endtask

    task automatic test_single_edge();
        do_reset();
        exp_q.push_back(2'd2);
        sig_in[2] = 1'b1;
        tick();
        checks++;
        if (pending !== 4'h0 || evt_if.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_k: got pend=%h valid=%b, required 0 0", pending, evt_if.evt_valid);
        end
        tick();
        checks++;
        if (pending !== 4'h4 || evt_if.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_k1: got pend=%h valid=%b, required 4 0", pending, evt_if.evt_valid);
        end
        tick();
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd2 || pending !== 4'h0) begin
            errors++;
            $display("FAIL single_k2: got valid=%b id=%0d pend=%h, required 1 2 0",
                     evt_if.evt_valid, evt_if.evt_id, pending);
        end
        tick();
        checks++;
        if (evt_if.evt_valid !== 1'b0 || ovf !== 4'h0) begin
            errors++;
            $display("FAIL single_k3: got valid=%b ovf=%h, required 0 0", evt_if.evt_valid, ovf);
        end
        sig_in = '0;
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_drain: got %0d outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N_CH; i++) exp_q.push_back(ID_W'(i));
        sig_in = 4'hF;
        for (int i = 1; i <= 7; i++) begin
            tick();
            sig_in = '0;
            if (i >= 3 && i <= 6) begin
                checks++;
                if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== ID_W'(i - 3)) begin
                    errors++;
                    $display("FAIL rr_all: got valid=%b id=%0d, required 1 %0d",
                             evt_if.evt_valid, evt_if.evt_id, i - 3);
                end
            end
        end
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        sig_in = 4'b1010;
        for (int i = 1; i <= 4; i++) begin
            tick();
            sig_in = '0;
            if (i >= 3) begin
                checks++;
                if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== ((i == 3) ? 2'd1 : 2'd3)) begin
                    errors++;
                    $display("FAIL rr_pair: got valid=%b id=%0d, required 1 %0d",
                             evt_if.evt_valid, evt_if.evt_id, (i == 3) ? 1 : 3);
                end
            end
        end
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_drain: got %0d outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure_ovf();
        do_reset();
        evt_if.evt_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            sig_in[1] = (i == 1 || i == 4 || i == 7);
            tick();
            if (i >= 3) begin
                checks++;
                if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd1) begin
                    errors++;
                    $display("FAIL bp_stable: got valid=%b id=%0d, required 1 1",
                             evt_if.evt_valid, evt_if.evt_id);
                end
            end
        end
        sig_in = '0;
        checks++;
        if (ovf !== 4'h2 || pending !== 4'h2) begin
            errors++;
            $display("FAIL bp_ovf: got ovf=%h pend=%h, required 2 2", ovf, pending);
        end
        ovf_clr[1] = 1'b1;
        tick();
        ovf_clr = '0;
        checks++;
        if (ovf !== 4'h0) begin
            errors++;
            $display("FAIL bp_ovf_clr: got ovf=%h, required 0", ovf);
        end
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        evt_if.evt_ready = 1'b1;
        wait_drain();
        checks++;
        if (exp_q.size() != 0 || pending !== 4'h0) begin
            errors++;
            $display("FAIL bp_drain: got %0d outstanding pend=%h, required 0 0", exp_q.size(), pending);
        end
    endtask

    task automatic test_collision();
        do_reset();
        evt_if.evt_ready = 1'b0;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        for (int i = 1; i <= 9; i++) begin
            sig_in[0]        = (i == 1 || i == 4 || i == 7);
            evt_if.evt_ready = (i >= 8);
            tick();
            if (i == 8) begin
                checks++;
                if (pending !== 4'h1 || ovf !== 4'h0 || evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd0) begin
                    errors++;
                    $display("FAIL collide: got pend=%h ovf=%h valid=%b id=%0d, required 1 0 1 0",
                             pending, ovf, evt_if.evt_valid, evt_if.evt_id);
                end
            end
        end
        sig_in = '0;
        checks++;
        if (pending !== 4'h0) begin
            errors++;
            $display("FAIL collide_clear: got pend=%h, required 0", pending);
        end
        wait_drain();
        checks++;
        if (exp_q.size() != 0 || ovf !== 4'h0) begin
            errors++;
            $display("FAIL collide_drain: got %0d outstanding ovf=%h, required 0 0", exp_q.size(), ovf);
        end
    endtask

    task automatic test_enable_reset();
        do_reset();
        sig_in[2] = 1'b1;
        tick();
        sig_in = '0;
        tick();
        checks++;
        if (pending !== 4'h4) begin
            errors++;
            $display("FAIL en_pend: got pend=%h, required 4", pending);
        end
        ch_en[2] = 1'b0;
        tick();
        checks++;
        if (pending !== 4'h0 || evt_if.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL en_drop: got pend=%h valid=%b, required 0 0", pending, evt_if.evt_valid);
        end
        repeat (3) tick();
        checks++;
        if (evt_if.evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL en_noevt: got valid=%b, required 0", evt_if.evt_valid);
        end
        ch_en = 4'hF;
        evt_if.evt_ready = 1'b0;
        sig_in[1] = 1'b1;
        tick();
        sig_in = '0;
        tick();
        tick();
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd1) begin
            errors++;
            $display("FAIL rst_hold: got valid=%b id=%0d, required 1 1", evt_if.evt_valid, evt_if.evt_id);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (evt_if.evt_valid !== 1'b0 || pending !== 4'h0) begin
            errors++;
            $display("FAIL rst_async: got valid=%b pend=%h, required 0 0", evt_if.evt_valid, pending);
        end
        sig_in[0] = 1'b1;
        evt_if.evt_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        exp_q.push_back(2'd0);
        wait_drain();
        repeat (4) tick();
        sig_in = '0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_release_evt: got %0d outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_round_robin();
        test_backpressure_ovf();
        test_collision();
        test_enable_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
